mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide unit for the EX stage of the 32-bit MIPS pipeline.
//   Consumes the two operands read from the register file (rs/rt) and owns the HI/LO registers.
//   Executes MULT/MULTU/DIV/DIVU in DATA_W cycles, and MTHI/MTLO in a single cycle.
//   Exposes busy to the hazard logic, which stalls MFHI/MFLO and further MDU ops.
// PARAMETERS
//   DATA_W   32   operand width; HI/LO are each DATA_W bits; iteration count = DATA_W
// PORTS
//   clk      in   1        clock; all state updates on posedge
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        issue strobe; sampled with op on a posedge
//   op       in   3        operation code (mdu_pkg encoding)
//   rs_data  in   DATA_W   operand A: multiplicand / dividend / MTHI,MTLO source
//   rt_data  in   DATA_W   operand B: multiplier / divisor
//   flush    in   1        cancel the in-flight iterative op (branch/exception squash)
//   busy     out  1        iterative op in flight
//   done     out  1        one-cycle pulse: HI/LO updated by an iterative op
//   hi       out  DATA_W   HI register
//   lo       out  DATA_W   LO register
// BEHAVIOUR
//   Reset: busy=0, done=0, hi=0, lo=0, counter=0, FSM=IDLE; asynchronous assertion.
//   FSM: IDLE -> RUN on accepted start with an iterative op.
//        RUN -> FIN when the counter reaches 0.
//        FIN -> IDLE in 1 cycle: HI/LO written; done=1 during the cycle after the write edge.
//   Accept: start is accepted only in IDLE. start while busy=1 is ignored; no queueing.
//   Latency: start accepted at edge E0 -> busy=1 from E0 through E(DATA_W) -> HI/LO and done
//     visible after E(DATA_W+1), where busy=0. Back-to-back start on the done cycle is accepted.
//   MTHI/MTLO (accepted in IDLE only): hi/lo <= rs_data at E0; busy and done stay 0.
//   MULT/MULTU: shift-add over DATA_W steps. {hi,lo} <= full 2*DATA_W product.
//     Signed: multiply operand magnitudes, then negate the product if the signs differ.
//   DIV/DIVU: restoring division over DATA_W steps. lo <= quotient, hi <= remainder.
//     Signed: quotient negated if the signs differ; remainder takes the dividend's sign.
//   Divide by zero (rt_data=0, signed or unsigned): lo=all-ones, hi=rs_data. No trap.
//   Signed overflow (-2^(W-1) / -1): lo=32'h8000_0000, hi=0.
//   Operands are latched at E0; rs_data/rt_data may change freely while busy.
//   flush while busy: at the next edge FSM->IDLE, busy=0, done=0, HI/LO unchanged.
//     flush in IDLE has no effect; flush and start in the same cycle -> flush wins, start dropped.
//   flush in the FIN cycle: the HI/LO write is suppressed.
//   Reset mid-operation: everything returns to reset values immediately.
//   Undefined/disabled op codes with start: ignored (no state change).
// CONFIGURATION
//   MDU_MADD_EN defined: op 110=MADD, 111=MADDU, same iterative latency as MULT.
//     {hi,lo} <= {hi,lo} + product, computed modulo 2^(2*DATA_W).
//     The accumulate uses the {hi,lo} value at completion.
//   MDU_MADD_EN undefined: ops 110/111 are ignored like undefined codes; no accumulator adder.
// STRUCTURE
//   mdu_pkg: op codes OP_MULT=3'b000, OP_MULTU=001, OP_DIV=010, OP_DIVU=011, OP_MTHI=100,
//     OP_MTLO=101, OP_MADD=110, OP_MADDU=111; FSM state constants IDLE/RUN/FIN;
//     function is_iterative(op).
//   Sub-module mdu_divider: restoring-division datapath (remainder/quotient shift register,
//     step strobe, magnitude in/out).
//   Top level holds the FSM, counter, multiplier datapath, sign fix-up and HI/LO.
// TESTING
//   MULTU 32'hFFFF_FFFF * 32'hFFFF_FFFF -> after 33 cycles hi=FFFF_FFFE, lo=0000_0001, done pulse.
//   MULT -7 * 3 -> hi=FFFF_FFFF, lo=FFFF_FFEB.
//   DIV -7 / 2 -> lo=FFFF_FFFD, hi=FFFF_FFFF.
//   DIVU 100 / 0 -> lo=FFFF_FFFF, hi=100.
//   MTLO 5, then MULT 6*7; flush at cycle 10 -> busy drops, lo stays 5, hi unchanged, no done.
//     A second start while busy is ignored.
//   MDU_MADD_EN defined: MTHI 0, MTLO 10, MADD 4*5 -> lo=30, hi=0.
//     Same sequence with the macro undefined -> lo stays 10.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
// MDU_MADD_EN enables the MADD/MADDU accumulate ops.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MADD  = 3'b110,
    OP_MADDU = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mdu_state_e;

  function automatic logic is_iterative(input logic [2:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) ||
        (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU);
`endif
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// Restoring divider on operand magnitudes, one quotient bit per step.
// Quotient shifts in where the dividend shifts out.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quo_o,
  output logic [DATA_W-1:0] rem_o
);

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W:0]   shl, diff;

  always_comb begin
    shl  = {rem_q, quo_q[DATA_W-1]};
    diff = shl - {1'b0, dvs_q};
    // borrow out means the trial subtract failed: keep the shifted value
    if (diff[DATA_W]) begin
      rem_d = shl[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b0};
    end else begin
      rem_d = diff[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/DIV unit owning HI/LO; MTHI/MTLO complete in one cycle.
// MDU_MADD_EN adds MADD/MADDU accumulating into {HI,LO}.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  mdu_state_e          state_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q, done_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   a_q, mcand_q;
  logic [2:0]          op_q;
  logic                neg_q, rneg_q, dz_q;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W:0]     sum;

  logic                op_sgn, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic                accept, div_step;
  logic [DATA_W-1:0]   quo, rem;
  logic [2*DATA_W-1:0] mul_res, fin_hilo;

  always_comb begin
    op_sgn = (op == OP_MULT) || (op == OP_DIV) ||
             (op == OP_MADD);
    a_neg  = op_sgn & rs_data[DATA_W-1];
    b_neg  = op_sgn & rt_data[DATA_W-1];
    a_mag  = a_neg ? -rs_data : rs_data;
    b_mag  = b_neg ? -rt_data : rt_data;
  end

  assign accept = (state_q == IDLE) && start &&
                  !flush && is_iterative(op);
  assign div_step = (state_q == RUN) && !flush;

  mdu_divider #(
    .DATA_W(DATA_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .step_i    (div_step),
    .dividend_i(a_mag),
    .divisor_i (b_mag),
    .quo_o     (quo),
    .rem_o     (rem)
  );

  // shift-add: low half holds the unconsumed multiplier bits
  always_comb begin
    sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]} +
          (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {sum, prod_q[DATA_W-1:1]};
  end

  always_comb begin
    mul_res  = neg_q ? -prod_q : prod_q;
    fin_hilo = mul_res;
`ifdef MDU_MADD_EN
    if (op_q == OP_MADD || op_q == OP_MADDU)
      fin_hilo = {hi_q, lo_q} + mul_res;
`endif
    if (op_q == OP_DIV || op_q == OP_DIVU) begin
      if (dz_q)
        fin_hilo = {a_q, {DATA_W{1'b1}}};
      else
        fin_hilo = {rneg_q ? -rem : rem,
                    neg_q ? -quo : quo};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      mcand_q <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      prod_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            accept: begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_LAST;
              op_q    <= op;
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              dz_q    <= (rt_data == '0);
              a_q     <= rs_data;
              mcand_q <= a_mag;
              prod_q  <= {{DATA_W{1'b0}}, b_mag};
            end
            (start && !flush && op == OP_MTHI):
              hi_q <= rs_data;
            (start && !flush && op == OP_MTLO):
              lo_q <= rs_data;
            default: ;
          endcase
        end
        RUN: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            prod_q <= prod_d;
            if (cnt_q == '0)
              state_q <= FIN;
            else
              cnt_q <= cnt_q - 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush) begin
            {hi_q, lo_q} <= fin_hilo;
            done_q       <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
